memaccess_stage: RTL and testbench

- LC-3 pipeline memory-access stage, directly downstream of the execute stage.
- Consumes execute results (pcout, aluout, M_Data, IR_Exec, Mem_Control_out).
- Performs LD/LDR/LDI/ST/STR/STI transactions on the data memory through a req/ready handshake, including the two-access indirect sequence.
- Returns memout and a done pulse to writeback, and stall_mem to the pipeline controller.

---
 rtl/memaccess_pkg.sv | 22 ++
 rtl/memaccess_decode.sv | 40 ++++
 rtl/memaccess_stage.sv | 147 ++++++++++++++
 tb/tb_memaccess_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memaccess_pkg.sv
// Shared definitions for the LC-3 memory-access stage: memory opcodes,
// the stage state encoding and the word returned by an aborted access.
package memaccess_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  // Loaded in place of memory data when a watchdog abort ends a transaction
  localparam logic [15:0] TIMEOUT_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    IND,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/memaccess_decode.sv
// Opcode classifier for the memory-access stage: which opcodes touch data
// memory, which of those are loads, and which take the base+offset address.
module memaccess_decode
  import memaccess_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem,
  output logic       is_load,
  output logic       use_alu_addr
);

  // Classify the opcode; anything not listed is a non-memory instruction
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    is_mem       = 1'b0;
    is_load      = 1'b0;
    use_alu_addr = 1'b0;
    case (opcode)
      OP_LD, OP_LDI: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
      end
      OP_LDR: begin
        is_mem       = 1'b1;
        is_load      = 1'b1;
        use_alu_addr = 1'b1;
      end
      OP_ST, OP_STI: begin
        is_mem = 1'b1;
      end
      OP_STR: begin
        is_mem       = 1'b1;
        use_alu_addr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memaccess_stage.sv
// LC-3 memory-access stage. Accepts a load/store from execute, runs one
// (direct) or two (indirect: pointer read, then data access) req/ready
// transfers on the data memory, then pulses mem_done to writeback.
// Optional build macro MEM_TIMEOUT_EN adds a watchdog that aborts a stuck
// transfer after TIMEOUT_CYCLES and reports it on mem_error.
module memaccess_stage
  import memaccess_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_memaccess,
  input  logic              Mem_Control_in,
  input  logic [15:0]       IR_Exec,
  input  logic [ADDR_W-1:0] pcout,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [DATA_W-1:0] M_Data,
  output logic [ADDR_W-1:0] Data_addr,
  output logic [DATA_W-1:0] Data_din,
  output logic              Data_rd,
  output logic              Data_req,
  input  logic              Data_ready,
  input  logic [DATA_W-1:0] Data_dout,
  output logic [DATA_W-1:0] memout,
  output logic              mem_done,
  output logic              stall_mem
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              mem_error
`endif
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              load_q;

  logic is_mem;
  logic is_load;
  logic use_alu_addr;
  logic busy;
  logic accept;
  logic timeout_hit;

  // Only the opcode field matters here; the operand bits were consumed upstream
  logic unused_ir;
  assign unused_ir = ^IR_Exec[11:0];

  memaccess_decode u_decode (
    .opcode       (IR_Exec[15:12]),
    .is_mem       (is_mem),
    .is_load      (is_load),
    .use_alu_addr (use_alu_addr)
  );

  assign busy   = (state_q == IND) || (state_q == ACC);
  assign accept = ((state_q == IDLE) || (state_q == DONE)) && enable_memaccess && is_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] wait_cnt_q;
  logic          err_q;

  assign timeout_hit = busy && !Data_ready && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on the current transfer; flag an abort for one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (accept || !busy || Data_ready) begin
        wait_cnt_q <= '0;
      end else begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign mem_error = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Stage sequencer: accept, optional pointer read, data access, done pulse
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      memout  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            addr_q  <= use_alu_addr ? aluout : pcout;
            data_q  <= M_Data;
            load_q  <= is_load;
            state_q <= Mem_Control_in ? IND : ACC;
          end else begin
            state_q <= IDLE;
          end
        end
        IND: begin
          if (Data_ready) begin
            addr_q  <= ADDR_W'(Data_dout);
            state_q <= ACC;
          end
        end
        ACC: begin
          if (Data_ready) begin
            if (load_q) begin
              memout <= Data_dout;
            end
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A watchdog abort overrides whatever the transfer was about to do
      if (timeout_hit) begin
        state_q <= DONE;
        memout  <= DATA_W'(TIMEOUT_WORD);
      end
    end
  end

  // Bus and status outputs decode straight from registered state, so an
  // asynchronous reset drops Data_req immediately and nothing is input-driven
  assign Data_req  = busy;
  assign stall_mem = busy;
  assign mem_done  = (state_q == DONE);
  assign Data_rd   = !((state_q == ACC) && !load_q);
  assign Data_addr = addr_q;
  assign Data_din  = data_q;

endmodule

// File: tb/tb_memaccess_stage.sv
// Self-checking bench for memaccess_stage: a word-array memory responder,
// a transaction-level expectation queue, and one per-cycle compare process.
module tb_memaccess_stage;
  import memaccess_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_memaccess = 1'b0;
  logic        Mem_Control_in = 1'b0;
  logic [15:0] IR_Exec = 16'h0;
  logic [15:0] pcout = 16'h0;
  logic [15:0] aluout = 16'h0;
  logic [15:0] M_Data = 16'h0;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_rd;
  logic        Data_req;
  logic        Data_ready = 1'b1;
  logic [15:0] Data_dout;
  logic [15:0] memout;
  logic        mem_done;
  logic        stall_mem;
`ifdef MEM_TIMEOUT_EN
  logic        mem_error;
`endif

  memaccess_stage dut (
    .clock            (clock),
    .reset            (reset),
    .enable_memaccess (enable_memaccess),
    .Mem_Control_in   (Mem_Control_in),
    .IR_Exec          (IR_Exec),
    .pcout            (pcout),
    .aluout           (aluout),
    .M_Data           (M_Data),
    .Data_addr        (Data_addr),
    .Data_din         (Data_din),
    .Data_rd          (Data_rd),
    .Data_req         (Data_req),
    .Data_ready       (Data_ready),
    .Data_dout        (Data_dout),
    .memout           (memout),
    .mem_done         (mem_done),
    .stall_mem        (stall_mem)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_error        (mem_error)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Data memory: combinational read, write on a completed store transfer
  logic [15:0] mem [0:65535];
  assign Data_dout = mem[Data_addr];
  always @(posedge clock) begin
    if (!reset && Data_req && Data_ready && !Data_rd) mem[Data_addr] = Data_din;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One expected transaction, derived from opcode rules and memory contents
  typedef struct {
    logic        load;
    logic        ind;
    logic        tmo;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] wdata;
    logic [15:0] exp_out;
    int          exp_stall;
    int          acc_cyc;
  } op_t;

  op_t         q[$];
  logic [15:0] model_out = 16'h0;

  // Present an op for one edge (caller is at posedge+1 with the stage idle/done)
  task automatic issue(input logic [3:0] op, input logic ind, input logic [15:0] pc,
                       input logic [15:0] alu, input logic [15:0] md,
                       input int stall, input logic tmo);
    op_t         t;
    logic [15:0] a;
    enable_memaccess = 1'b1;
    IR_Exec          = {op, 12'h5A3};
    Mem_Control_in   = ind;
    pcout            = pc;
    aluout           = alu;
    M_Data           = md;
    t.load    = (op == OP_LD) || (op == OP_LDI) || (op == OP_LDR);
    a         = ((op == OP_LDR) || (op == OP_STR)) ? alu : pc;
    t.a0      = a;
    t.a1      = ind ? mem[a] : a;
    t.ind     = ind;
    t.tmo     = tmo;
    t.wdata   = md;
    t.exp_out = tmo ? 16'hDEAD : (t.load ? mem[t.a1] : model_out);
    t.exp_stall = stall;
    model_out = t.exp_out;
    @(posedge clock);
    #1;
    t.acc_cyc = cyc;
    q.push_back(t);
    // Scramble upstream inputs; the stage must ignore them from here on
    enable_memaccess = 1'b0;
    IR_Exec          = 16'h1FFF;
    Mem_Control_in   = ~ind;
    pcout            = ~pc;
    aluout           = ~alu;
    M_Data           = ~md;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    if (q.size() > 0) begin
      check({name, "_done_timeout"}, q.size(), 0);
      q.delete();
    end
    #1;
  endtask

  // Per-cycle compare against the expectation queue
  int          xfer_idx = 0;
  int          stall_cnt = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr, prev_din;
  logic        prev_rd;

  always @(negedge clock) begin
    op_t  t;
    logic exp_busy;
    logic last;
    if (reset) begin
      xfer_idx  = 0;
      stall_cnt = 0;
      prev_wait = 1'b0;
    end else begin
      exp_busy = (q.size() > 0) && !mem_done;
      check("stall_mem", stall_mem, exp_busy);
      check("Data_req", Data_req, exp_busy);
      if (prev_wait) begin
        check("hold_addr", Data_addr, prev_addr);
        check("hold_din", Data_din, prev_din);
        check("hold_rd", Data_rd, prev_rd);
      end
      prev_wait = Data_req && !Data_ready;
      prev_addr = Data_addr;
      prev_din  = Data_din;
      prev_rd   = Data_rd;
      if (Data_req) stall_cnt++;
      if (Data_req && Data_ready && q.size() > 0) begin
        t    = q[0];
        last = (xfer_idx == (t.ind ? 1 : 0));
        check("xfer_addr", Data_addr, (xfer_idx == 0) ? t.a0 : t.a1);
        check("xfer_rd", Data_rd, last ? t.load : 1'b1);
        if (last && !t.load) check("xfer_din", Data_din, t.wdata);
        xfer_idx++;
      end
      if (mem_done) begin
        if (q.size() == 0) begin
          check("mem_done_unexpected", mem_done, 1'b0);
        end else begin
          t = q.pop_front();
          check("memout", memout, t.exp_out);
          check("stall_cycles", stall_cnt, t.exp_stall);
          check("done_latency", cyc - t.acc_cyc + 1, t.exp_stall + 1);
          check("xfer_count", xfer_idx, t.tmo ? 0 : (t.ind ? 2 : 1));
          if (!t.load && !t.tmo) check("mem_write", mem[t.a1], t.wdata);
`ifdef MEM_TIMEOUT_EN
          check("mem_error_at_done", mem_error, t.tmo);
`endif
        end
        xfer_idx  = 0;
        stall_cnt = 0;
      end
`ifdef MEM_TIMEOUT_EN
      else begin
        check("mem_error_idle", mem_error, 1'b0);
      end
`endif
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[16'h3010] = 16'hBEEF;
    mem[16'h2000] = 16'h4000;
    mem[16'h0050] = 16'hCAFE;
    mem[16'h0200] = 16'h0100;
    mem[16'h0070] = 16'h7777;

    // Reset state
    #2;
    check("rst_req", Data_req, 1'b0);
    check("rst_rd", Data_rd, 1'b1);
    check("rst_done", mem_done, 1'b0);
    check("rst_stall", stall_mem, 1'b0);
    check("rst_memout", memout, 16'h0);
    check("rst_addr", Data_addr, 16'h0);
    check("rst_din", Data_din, 16'h0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // LDR from base+offset, ready tied high
    issue(OP_LDR, 1'b0, 16'h1111, 16'h3010, 16'h0000, 1, 1'b0);
    check("ldr_addr_n1", Data_addr, 16'h3010);
    check("ldr_rd_n1", Data_rd, 1'b1);
    wait_idle("ldr");
    check("ldr_memout", memout, 16'hBEEF);

    // STI: pointer read at 2000, then write 1234 to 4000
    issue(OP_STI, 1'b1, 16'h2000, 16'h0000, 16'h1234, 2, 1'b0);
    check("sti_ptr_addr", Data_addr, 16'h2000);
    wait_idle("sti");
    check("sti_write", mem[16'h4000], 16'h1234);
    check("sti_memout_kept", memout, 16'hBEEF);

    // LD with ready low for 3 cycles; a store offered meanwhile must be ignored
    Data_ready = 1'b0;
    issue(OP_LD, 1'b0, 16'h0050, 16'h0000, 16'h0000, 4, 1'b0);
    enable_memaccess = 1'b1;
    IR_Exec          = {OP_ST, 12'h000};
    pcout            = 16'h0999;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    Data_ready       = 1'b1;
    enable_memaccess = 1'b0;
    wait_idle("ld_wait");
    check("ld_wait_memout", memout, 16'hCAFE);

    // Non-memory opcode with enable held
    enable_memaccess = 1'b1;
    IR_Exec          = 16'h1042;
    repeat (4) begin
      @(posedge clock);
      #1;
      check("add_req", Data_req, 1'b0);
      check("add_done", mem_done, 1'b0);
      check("add_stall", stall_mem, 1'b0);
    end
    enable_memaccess = 1'b0;

    // ST then LDI through pointer 0200 -> 0100
    issue(OP_ST, 1'b0, 16'h0100, 16'h0000, 16'hA5A5, 1, 1'b0);
    wait_idle("st");
    issue(OP_LDI, 1'b1, 16'h0200, 16'h0000, 16'h0000, 2, 1'b0);
    wait_idle("ldi");
    check("ldi_memout", memout, 16'hA5A5);

    // Back-to-back: LD accepted in the STR's done cycle
    issue(OP_STR, 1'b0, 16'h0000, 16'h0300, 16'h1357, 1, 1'b0);
    n = 0;
    while (!mem_done && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!mem_done) check("b2b_wait_done", mem_done, 1'b1);
    issue(OP_LD, 1'b0, 16'h0300, 16'h0000, 16'h0000, 1, 1'b0);
    check("b2b_no_bubble", stall_mem, 1'b1);
    wait_idle("b2b");
    check("b2b_memout", memout, 16'h1357);

    // Reset in the middle of an access
    Data_ready = 1'b0;
    issue(OP_LD, 1'b0, 16'h0060, 16'h0000, 16'h0000, 0, 1'b0);
    @(posedge clock);
    #1;
    check("pre_reset_req", Data_req, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", Data_req, 1'b0);
    check("mid_rst_stall", stall_mem, 1'b0);
    check("mid_rst_done", mem_done, 1'b0);
    check("mid_rst_memout", memout, 16'h0);
    check("mid_rst_rd", Data_rd, 1'b1);
    check("mid_rst_addr", Data_addr, 16'h0);
    q.delete();
    model_out = 16'h0;
    @(posedge clock);
    #2;
    reset      = 1'b0;
    Data_ready = 1'b1;
    @(posedge clock);
    #1;
    issue(OP_LD, 1'b0, 16'h0070, 16'h0000, 16'h0000, 1, 1'b0);
    wait_idle("post_rst_ld");
    check("post_rst_memout", memout, 16'h7777);

`ifdef MEM_TIMEOUT_EN
    // Memory never responds: watchdog abort after 16 waiting cycles
    Data_ready = 1'b0;
    issue(OP_LD, 1'b0, 16'h0400, 16'h0000, 16'h0000, 16, 1'b1);
    wait_idle("timeout");
    check("tmo_memout", memout, 16'hDEAD);
    check("tmo_req_dropped", Data_req, 1'b0);
    Data_ready = 1'b1;
`endif

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
